// File: rtl/pipe_pkg.sv
// Shared widths, bus field offsets, one-hot opcodes and MUL state encoding
// for the execute stage of the 8-bit teaching pipeline.
package pipe_pkg;

    localparam int DS_TO_ES_BUS_W = 28;
    localparam int ES_TO_WS_BUS_W = 14;

    localparam logic [3:0] OP_ADD = 4'b1000;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_LI  = 4'b0001;

    localparam int DS_OP_LSB  = 24;
    localparam int DS_RY_LSB  = 16;
    localparam int DS_RX_LSB  = 8;
    localparam int DS_IMM_LSB = 0;

    localparam int ES_CARRY_BIT = 13;
    localparam int ES_ZERO_BIT  = 12;
    localparam int ES_OP_LSB    = 8;
    localparam int ES_RES_LSB   = 0;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/exe_stage_if.sv
// Decode->execute->writeback handshake and bus signals seen by the execute stage.
interface exe_stage_if;
    import pipe_pkg::*;

    logic                      ds_to_es_valid;
    logic [DS_TO_ES_BUS_W-1:0] ds_to_es_bus;
    logic                      es_allowin;
    logic                      es_to_ws_valid;
    logic                      ws_allowin;
    logic [ES_TO_WS_BUS_W-1:0] es_to_ws_bus;

    modport master (
        output ds_to_es_valid, ds_to_es_bus, ws_allowin,
        input  es_allowin, es_to_ws_valid, es_to_ws_bus
    );

    modport slave (
        input  ds_to_es_valid, ds_to_es_bus, ws_allowin,
        output es_allowin, es_to_ws_valid, es_to_ws_bus
    );

endinterface

// File: rtl/exe_stage_mul8.sv
// Iterative 8x8 shift-add multiplier: one multiplier bit per clock, 8 clocks per product.
// state    | meaning
// MUL_IDLE | no multiply in flight
// MUL_BUSY | accumulating partial products, cnt = bit being processed
// MUL_DONE | product valid, held until consumed or restarted
module es_mul8
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic        consume,
    output logic        busy,
    output logic        done,
    output logic [15:0] product
);

    mul_state_t  state, state_nxt;
    logic [2:0]  cnt;
    logic [15:0] mcand;
    logic [7:0]  mplier;
    logic [15:0] acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= MUL_IDLE;
            cnt    <= 3'd0;
            mcand  <= 16'h0000;
            mplier <= 8'h00;
            acc    <= 16'h0000;
        end else begin
            state <= state_nxt;
            if (start && state != MUL_BUSY) begin
                cnt    <= 3'd0;
                acc    <= 16'h0000;
                mcand  <= {8'h00, a};
                mplier <= b;
            end else if (state == MUL_BUSY) begin
                if (mplier[0]) acc <= acc + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 3'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MUL_IDLE: if (start) state_nxt = MUL_BUSY;
            MUL_BUSY: if (cnt == 3'd7) state_nxt = MUL_DONE;
            // a back-to-back MUL restarts directly rather than passing through IDLE
            MUL_DONE: begin
                if (start)        state_nxt = MUL_BUSY;
                else if (consume) state_nxt = MUL_IDLE;
            end
            default:  state_nxt = MUL_IDLE;
        endcase
    end

    assign busy    = (state == MUL_BUSY);
    assign done    = (state == MUL_DONE);
    assign product = acc;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: latches the decode bundle, computes ADD/SUB/LI in one cycle
// and MUL over 8 extra cycles, and presents result/flags to writeback.
module exe_stage
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    exe_stage_if.slave  es_io
);

    logic [DS_TO_ES_BUS_W-1:0] es_bus;
    logic                      es_valid;
    logic                      es_ready_go;
    logic                      load;
    logic                      drain;
    logic [3:0]                es_op;
    logic [7:0]                es_rx, es_ry, es_imm;
    logic                      mul_start, mul_busy, mul_done;
    logic [15:0]               mul_product;
    logic [8:0]                sum9;
    logic [7:0]                result;
    logic                      carry;

    assign es_op  = es_bus[DS_OP_LSB  +: 4];
    assign es_ry  = es_bus[DS_RY_LSB  +: 8];
    assign es_rx  = es_bus[DS_RX_LSB  +: 8];
    assign es_imm = es_bus[DS_IMM_LSB +: 8];

    assign es_ready_go          = !(es_op == OP_MUL && !mul_done);
    assign es_io.es_allowin     = !es_valid || (es_ready_go && es_io.ws_allowin);
    assign es_io.es_to_ws_valid = es_valid && es_ready_go;
    assign load                 = es_io.ds_to_es_valid && es_io.es_allowin;
    assign drain                = es_io.es_to_ws_valid && es_io.ws_allowin;

    always_ff @(posedge clk) begin
        if (reset) begin
            es_valid <= 1'b0;
            es_bus   <= '0;
        end else if (load) begin
            es_valid <= 1'b1;
            es_bus   <= es_io.ds_to_es_bus;
        end else if (drain) begin
            es_valid <= 1'b0;
        end
    end

    // operands come straight off the incoming bundle so BUSY starts on the load edge
    assign mul_start = load && !mul_busy
                       && (es_io.ds_to_es_bus[DS_OP_LSB +: 4] == OP_MUL);

    es_mul8 u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (es_io.ds_to_es_bus[DS_RX_LSB +: 8]),
        .b       (es_io.ds_to_es_bus[DS_RY_LSB +: 8]),
        .consume (drain),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        sum9   = 9'd0;
        result = 8'h00;
        carry  = 1'b0;
        case (es_op)
            OP_ADD: begin
                sum9   = {1'b0, es_rx} + {1'b0, es_ry};
                result = sum9[7:0];
                carry  = sum9[8];
            end
            OP_SUB: begin
                result = es_rx - es_ry;
                carry  = (es_rx < es_ry);
            end
            OP_MUL: begin
                result = mul_product[7:0];
                carry  = |mul_product[15:8];
            end
            OP_LI:   result = es_imm;
            default: ;
        endcase
    end

    assign es_io.es_to_ws_bus = {carry, (result == 8'h00), es_op, result};

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed test-plan steps plus random
// bundles compared against an arithmetic reference model.
module tb_exe_stage;
    import pipe_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    exe_stage_if es_io ();

    exe_stage dut (
        .clk   (clk),
        .reset (reset),
        .es_io (es_io)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // reference: plain integer arithmetic on the op rules
    function automatic logic [13:0] model(input logic [3:0] op, input logic [7:0] rx,
                                          input logic [7:0] ry, input logic [7:0] imm);
        int r;
        int c;
        r = 0;
        c = 0;
        case (op)
            4'b1000: begin r = int'(rx) + int'(ry); c = (r > 255) ? 1 : 0; r = r % 256; end
            4'b0100: begin c = (rx < ry) ? 1 : 0; r = (int'(rx) - int'(ry) + 256) % 256; end
            4'b0010: begin r = int'(rx) * int'(ry); c = (r > 255) ? 1 : 0; r = r % 256; end
            4'b0001: r = int'(imm);
            default: begin r = 0; c = 0; end
        endcase
        return {c[0], (r == 0), op, 8'(r)};
    endfunction

    function automatic bit is_onehot(input logic [3:0] op);
        return (op == 4'b1000) || (op == 4'b0100) || (op == 4'b0010) || (op == 4'b0001);
    endfunction

    function automatic logic [27:0] bundle(input logic [3:0] op, input logic [7:0] rx,
                                           input logic [7:0] ry, input logic [7:0] imm);
        return {op, ry, rx, imm};
    endfunction

    task automatic do_reset();
        @(posedge clk) #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // present a bundle and return just after the edge that accepts it
    task automatic send(input logic [3:0] op, input logic [7:0] rx,
                        input logic [7:0] ry, input logic [7:0] imm);
        int w;
        @(posedge clk) #1;
        es_io.ds_to_es_valid = 1'b1;
        es_io.ds_to_es_bus   = bundle(op, rx, ry, imm);
        w = 0;
        @(negedge clk);
        while (!es_io.es_allowin && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("accept_wait", 32'(es_io.es_allowin), 32'd1);
        @(posedge clk) #1;
        es_io.ds_to_es_valid = 1'b0;
    endtask

    // called just after the accept edge; lat counts cycles until es_to_ws_valid
    task automatic expect_out(input string tag, input logic [3:0] op, input logic [7:0] rx,
                              input logic [7:0] ry, input logic [7:0] imm);
        int lat;
        int lo;
        int exp_lat;
        logic [13:0] exp;
        exp_lat = (op == OP_MUL) ? 9 : 1;
        exp = model(op, rx, ry, imm);
        lat = 1;
        lo  = 0;
        @(negedge clk);
        while (!es_io.es_to_ws_valid && lat < 20) begin
            if (!es_io.es_allowin) lo++;
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_stall_cycles"}, 32'(lo), 32'(exp_lat - 1));
        if (is_onehot(op) || op == 4'b0000)
            check({tag, "_bus"}, 32'(es_io.es_to_ws_bus), 32'(exp));
        else
            check({tag, "_flags_res"}, 32'({es_io.es_to_ws_bus[13:12], es_io.es_to_ws_bus[7:0]}),
                  32'({exp[13:12], exp[7:0]}));
    endtask

    initial begin
        logic [3:0] op;
        logic [7:0] rx, ry, imm;
        logic [3:0] op_tab [6];

        reset = 1'b1;
        es_io.ds_to_es_valid = 1'b0;
        es_io.ds_to_es_bus   = '0;
        es_io.ws_allowin     = 1'b1;
        op_tab[0] = OP_ADD; op_tab[1] = OP_SUB; op_tab[2] = OP_MUL;
        op_tab[3] = OP_LI;  op_tab[4] = 4'b0000; op_tab[5] = 4'b0110;

        do_reset();
        @(negedge clk);
        check("rst_valid",   32'(es_io.es_to_ws_valid), 32'd0);
        check("rst_allowin", 32'(es_io.es_allowin),     32'd1);
        check("rst_bus",     32'(es_io.es_to_ws_bus),   32'h1000);

        send(OP_ADD, 8'hF0, 8'h20, 8'h00); expect_out("add_carry", OP_ADD, 8'hF0, 8'h20, 8'h00);
        check("add_carry_const", 32'(es_io.es_to_ws_bus), 32'h2810);
        send(OP_SUB, 8'h05, 8'h07, 8'h00); expect_out("sub_borrow", OP_SUB, 8'h05, 8'h07, 8'h00);
        send(OP_SUB, 8'h33, 8'h33, 8'h00); expect_out("sub_zero", OP_SUB, 8'h33, 8'h33, 8'h00);
        send(4'b0000, 8'h12, 8'h34, 8'h56); expect_out("nop0", 4'b0000, 8'h12, 8'h34, 8'h56);
        send(4'b0110, 8'h12, 8'h34, 8'h56); expect_out("nop6", 4'b0110, 8'h12, 8'h34, 8'h56);

        // two MULs with the second waiting behind the first (DONE -> BUSY)
        @(posedge clk) #1;
        es_io.ds_to_es_valid = 1'b1;
        es_io.ds_to_es_bus   = bundle(OP_MUL, 8'd13, 8'd11, 8'h00);
        @(negedge clk);
        check("mul_a_allowin", 32'(es_io.es_allowin), 32'd1);
        @(posedge clk) #1;
        es_io.ds_to_es_bus = bundle(OP_MUL, 8'h10, 8'h20, 8'h00);
        expect_out("mul_13x11", OP_MUL, 8'd13, 8'd11, 8'h00);
        check("mul_13x11_const", 32'(es_io.es_to_ws_bus), 32'h028F);
        @(posedge clk) #1;
        es_io.ds_to_es_valid = 1'b0;
        expect_out("mul_ovf", OP_MUL, 8'h10, 8'h20, 8'h00);

        // back-pressure on LI, then drain and accept ADD on the same edge
        @(posedge clk) #1;
        es_io.ws_allowin = 1'b0;
        send(OP_LI, 8'h00, 8'h00, 8'hA5); expect_out("li", OP_LI, 8'h00, 8'h00, 8'hA5);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_valid",   32'(es_io.es_to_ws_valid), 32'd1);
            check("bp_bus",     32'(es_io.es_to_ws_bus),   32'h01A5);
            check("bp_allowin", 32'(es_io.es_allowin),     32'd0);
        end
        @(posedge clk) #1;
        es_io.ws_allowin     = 1'b1;
        es_io.ds_to_es_valid = 1'b1;
        es_io.ds_to_es_bus   = bundle(OP_ADD, 8'h01, 8'h02, 8'h00);
        @(negedge clk);
        check("release_allowin", 32'(es_io.es_allowin), 32'd1);
        @(posedge clk) #1;
        es_io.ds_to_es_valid = 1'b0;
        expect_out("after_bp", OP_ADD, 8'h01, 8'h02, 8'h00);

        // full throughput: consecutive single-cycle bundles
        @(posedge clk) #1;
        es_io.ds_to_es_valid = 1'b1;
        es_io.ds_to_es_bus   = bundle(OP_ADD, 8'h7F, 8'h01, 8'h00);
        @(negedge clk);
        check("tp_allowin0", 32'(es_io.es_allowin), 32'd1);
        @(posedge clk) #1;
        es_io.ds_to_es_bus = bundle(OP_SUB, 8'h00, 8'h01, 8'h00);
        @(negedge clk);
        check("tp_valid",    32'(es_io.es_to_ws_valid), 32'd1);
        check("tp_bus0",     32'(es_io.es_to_ws_bus),   32'(model(OP_ADD, 8'h7F, 8'h01, 8'h00)));
        check("tp_allowin1", 32'(es_io.es_allowin),     32'd1);
        @(posedge clk) #1;
        es_io.ds_to_es_valid = 1'b0;
        expect_out("tp_second", OP_SUB, 8'h00, 8'h01, 8'h00);

        // reset 4 cycles into a MUL aborts it
        send(OP_MUL, 8'hFF, 8'hFF, 8'h00);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk) #1;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("abort_valid",   32'(es_io.es_to_ws_valid), 32'd0);
            check("abort_allowin", 32'(es_io.es_allowin),     32'd1);
        end
        send(OP_ADD, 8'h01, 8'h01, 8'h00); expect_out("post_abort", OP_ADD, 8'h01, 8'h01, 8'h00);
        check("post_abort_res", 32'(es_io.es_to_ws_bus[7:0]), 32'h02);

        for (int i = 0; i < 40; i++) begin
            op  = op_tab[$urandom_range(0, 5)];
            rx  = 8'($urandom);
            ry  = 8'($urandom);
            imm = 8'($urandom);
            if (i % 7 == 3) op = 4'($urandom);
            send(op, rx, ry, imm);
            expect_out("rand", op, rx, ry, imm);
        end

        @(posedge clk) #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
